// File: rtl/if_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// The IF state encoding lives here so the bench and any debug tooling agree on it.
package if_fetch_pkg;

  localparam int unsigned IF_CPU_WIDTH = 16;
  localparam int unsigned IF_ADDR_W    = 16;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch_skid.sv
// One-entry {inst, pc} holding buffer used when the decoder stalls a returning fetch.
// Clear wins over load so a redirect on the same edge always leaves it empty.
module if_fetch_skid #(
  parameter int unsigned CPU_WIDTH = 16,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 clr_i,
  input  logic [CPU_WIDTH-1:0] inst_i,
  input  logic [ADDR_W-1:0]    pc_i,
  output logic                 vld_o,
  output logic [CPU_WIDTH-1:0] inst_o,
  output logic [ADDR_W-1:0]    pc_o
);

  logic                 vld_q,  vld_d;
  logic [CPU_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0]    pc_q,   pc_d;

  always_comb begin
    vld_d  = vld_q;
    inst_d = inst_q;
    pc_d   = pc_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d  = 1'b1;
      inst_d = inst_i;
      pc_d   = pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      inst_q <= inst_d;
      pc_q   <= pc_d;
    end
  end

  assign vld_o  = vld_q;
  assign inst_o = inst_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and feeds the
// decoder through the IF/ID register; branch redirect flushes everything on the same edge.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       CPU_WIDTH = IF_CPU_WIDTH,
  parameter int unsigned       ADDR_W    = IF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       PC_STEP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_rvalid,
  input  logic [CPU_WIDTH-1:0] imem_rdata,
  input  logic                 br_taken,
  input  logic [ADDR_W-1:0]    br_target,
  input  logic                 id_ready,
  output logic                 valid_o,
  output logic [CPU_WIDTH-1:0] inst_o,
  output logic [ADDR_W-1:0]    pc_o
);

  if_state_e            state_q,  state_d;
  logic [ADDR_W-1:0]    pc_q,     pc_d;
  logic                 valid_q,  valid_d;
  logic [CPU_WIDTH-1:0] inst_q,   inst_d;
  logic [ADDR_W-1:0]    pc_out_q, pc_out_d;

  logic                 out_free;
  logic [ADDR_W-1:0]    pc_inc;
  logic                 skid_load, skid_clr, skid_vld;
  logic [CPU_WIDTH-1:0] skid_inst;
  logic [ADDR_W-1:0]    skid_pc;

  assign out_free = ~valid_q | id_ready;
  assign pc_inc   = pc_q + ADDR_W'(PC_STEP);

  if_fetch_skid #(
    .CPU_WIDTH (CPU_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .clr_i  (skid_clr),
    .inst_i (imem_rdata),
    .pc_i   (pc_q),
    .vld_o  (skid_vld),
    .inst_o (skid_inst),
    .pc_o   (skid_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    pc_out_d  = pc_out_q;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    imem_req  = 1'b0;
    imem_addr = pc_q;

    if (valid_q && id_ready) valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          pc_d = pc_inc;
          if (out_free) begin
            // Chain the next fetch off the returning one for 1 instr/cycle.
            inst_d    = imem_rdata;
            pc_out_d  = pc_q;
            valid_d   = 1'b1;
            imem_req  = 1'b1;
            imem_addr = pc_inc;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (id_ready && skid_vld) begin
          inst_d   = skid_inst;
          pc_out_d = skid_pc;
          valid_d  = 1'b1;
          skid_clr = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_KILL: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (br_taken) begin
      pc_d      = br_target;
      valid_d   = 1'b0;
      skid_clr  = 1'b1;
      skid_load = 1'b0;
      imem_req  = 1'b0;
      // Only a response still in flight keeps us in S_KILL; one landing now is dropped.
      if ((state_q == S_WAIT || state_q == S_KILL) && !imem_rvalid) state_d = S_KILL;
      else                                                          state_d = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_out_q;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Sits directly upstream of the instruction decoder.
- Holds the PC and issues single-outstanding requests to the instruction memory.
- Presents {inst_o, pc_o, valid_o} to the decoder through an IF/ID output register.
- Handles a 1-entry skid buffer, decoder back-pressure, and branch redirect/flush from the compare/branch logic.

Parameters:
- CPU_WIDTH, 16, instruction/data width (matches `CPU_WIDTH).
- ADDR_W, 16, PC / instruction-memory address width.
- RESET_PC, 0, PC value after reset.
- PC_STEP, 1, PC increment per instruction (word-addressed memory).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  request strobe; one request accepted per asserted cycle.
- imem_addr  out  ADDR_W  request address, valid while imem_req=1.
- imem_rvalid  in  1  read data valid, 1 cycle pulse, arrives ≥1 cycle after req.
- imem_rdata  in  CPU_WIDTH  instruction word, valid with imem_rvalid.
- br_taken  in  1  redirect request from branch compare (BEQ/BLE resolved).
- br_target  in  ADDR_W  redirect PC, valid with br_taken.
- id_ready  in  1  decoder accepts inst_o this cycle.
- valid_o  out  1  inst_o/pc_o hold a live instruction.
- inst_o  out  CPU_WIDTH  instruction to decoder.
- pc_o  out  ADDR_W  address of inst_o.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-request): state=S_REQ, pc=RESET_PC, valid_o=0, inst_o=0 (opcode 0 decodes to all-zero controls), pc_o=0, skid empty. The response to a request in flight at reset is ignored; the bench must not return rvalid for it.
- out_free = ~valid_o | id_ready.
- States:
  - S_REQ: imem_req = ~br_taken; imem_addr = pc; on issue -> S_WAIT.
  - S_WAIT: waits for imem_rvalid.
    - rvalid & out_free: load inst_o=rdata, pc_o=pc, valid_o=1, pc+=PC_STEP. Issue the next request the same cycle (imem_req=1, imem_addr=pc+PC_STEP) and stay in S_WAIT, giving back-to-back throughput of 1 instr/cycle with 1-cycle memory.
    - rvalid & ~out_free: capture {rdata, pc} in skid, pc+=PC_STEP -> S_HOLD.
  - S_HOLD: no request. On id_ready, skid moves to output (valid_o stays 1), skid cleared -> S_REQ.
  - S_KILL: a redirect occurred with a request outstanding. On rvalid, discard the data -> S_REQ. No request is issued in this state.
- id_ready with valid_o=1 and no new data: valid_o <= 0.
- Redirect (br_taken=1), highest priority over all of the above, same edge:
  - pc <= br_target; valid_o <= 0; skid cleared; imem_req forced 0 that cycle.
  - From S_WAIT without rvalid -> S_KILL.
  - From S_WAIT with rvalid -> data discarded -> S_REQ.
  - From S_REQ/S_HOLD -> S_REQ.
  - From S_KILL -> stays S_KILL, with pc updated again.
- br_taken & id_ready same cycle: flush wins; inst_o is not re-presented.
- PC arithmetic is modulo 2^ADDR_W. pc = all-ones wraps to 0 without flag.
- Latency: req at cycle N, rvalid at N+1 -> valid_o=1 at N+2.
- Invariants:
  - At most one outstanding request.
  - Outputs change only when out_free or on redirect/reset.
  - inst_o/pc_o are stable while valid_o & ~id_ready.

Decomposition:
- para.v additions: IF state encodings (S_REQ, S_WAIT, S_HOLD, S_KILL as 2-bit `defines), `RESET_PC, `ADDR_W, reuse of `CPU_WIDTH/`DATABUS.
- One sub-module: if_skid (1-entry {inst,pc} buffer with load/clear/valid).
- FSM, PC, and output register stay in if_fetch.

Test Plan:
- Reset then 1-cycle memory returning inst=mem[addr] for addrs 0..3, id_ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; valid_o high from cycle 2; pc_o 0,1,2,3 back-to-back.
- id_ready=0 for 3 cycles after first instruction -> inst_o/pc_o=0 held stable; second word captured in skid, no third request; on id_ready=1, pc_o=1 next, then request addr 2 issued.
- br_taken=1, br_target=0x40 while a request to addr 5 is outstanding, memory delays rvalid 3 cycles -> valid_o=0 next edge; addr-5 data discarded; next request imem_addr=0x40; pc_o=0x40.
- br_taken coincident with rvalid and id_ready=0 (skid would load) -> data dropped, skid empty, valid_o=0, next req addr=br_target.
- rst asserted in S_HOLD with valid_o=1 -> next edge valid_o=0, inst_o=0, pc_o=0, imem_req=1 with addr RESET_PC.
- pc preloaded via br_target=0xFFFF -> after fetch, next imem_addr=0x0000.
